// File: rtl/ov7670_pkg.sv
// OV7670 capture path shared definitions.
// Default geometry, RGB565 width and frame writer FSM encoding.
package ov7670_pkg;

    localparam int OV_H_WIDTH = 320;
    localparam int OV_V_WIDTH = 240;
    localparam int RGB565_W   = 16;

    localparam logic [3:0] FSM_IDLE    = 4'b0001;
    localparam logic [3:0] FSM_ARMED   = 4'b0010;
    localparam logic [3:0] FSM_CAPTURE = 4'b0100;
    localparam logic [3:0] FSM_COMMIT  = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE    = FSM_IDLE,
        ST_ARMED   = FSM_ARMED,
        ST_CAPTURE = FSM_CAPTURE,
        ST_COMMIT  = FSM_COMMIT
    } fbw_state_e;

endpackage

// File: rtl/fb_addr_pipe.sv
// Two-stage pixel address pipeline: S1 range check and row offset,
// S2 column add, bank prepend and BRAM write strobe.
module fb_addr_pipe
    import ov7670_pkg::*;
#(
    parameter int  H_WIDTH   = OV_H_WIDTH,
    parameter int  V_WIDTH   = OV_V_WIDTH,
    parameter int  PXL_WIDTH = RGB565_W,
    localparam int PIX_AW    = $clog2(H_WIDTH * V_WIDTH),
    localparam int HAW       = $clog2(H_WIDTH) + 1,
    localparam int VAW       = $clog2(V_WIDTH) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_n_reset,
    input  logic [PXL_WIDTH-1:0] pixel_i,
    input  logic [HAW-1:0]       h_addr_i,
    input  logic [VAW-1:0]       v_addr_i,
    input  logic                 valid_i,
    input  logic                 accept_i,
    input  logic                 bank_i,
    output logic                 s1_valid_o,
    output logic                 s1_in_range_o,
    output logic                 s1_first_o,
    output logic                 s1_last_o,
    output logic                 wr_en_o,
    output logic [PIX_AW:0]      wr_addr_o,
    output logic [PXL_WIDTH-1:0] wr_data_o
);

    localparam logic [HAW-1:0]    H_LIM = HAW'(H_WIDTH);
    localparam logic [VAW-1:0]    V_LIM = VAW'(V_WIDTH);
    localparam logic [PIX_AW-1:0] H_MUL = PIX_AW'(H_WIDTH);

    logic [HAW-1:0] col;
    logic           in_range;

    logic                 s1_valid_q, s1_in_range_q, s1_first_q, s1_last_q;
    logic [PXL_WIDTH-1:0] s1_data_q;
    logic [HAW-1:0]       s1_col_q;
    logic [PIX_AW-1:0]    s1_row_off_q;

    logic                 wr_en_q;
    logic [PIX_AW:0]      wr_addr_q;
    logic [PXL_WIDTH-1:0] wr_data_q;

    // h_addr is 1-based; zero wraps col to all-ones and is rejected explicitly
    assign col      = h_addr_i - HAW'(1);
    assign in_range = (h_addr_i != '0) && (col < H_LIM) && (v_addr_i < V_LIM);

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            s1_valid_q    <= 1'b0;
            s1_in_range_q <= 1'b0;
            s1_first_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_data_q     <= '0;
            s1_col_q      <= '0;
            s1_row_off_q  <= '0;
        end else begin
            s1_valid_q    <= valid_i;
            s1_in_range_q <= in_range;
            s1_first_q    <= (col == '0) && (v_addr_i == '0);
            s1_last_q     <= (col == H_LIM - HAW'(1)) && (v_addr_i == V_LIM - VAW'(1));
            s1_data_q     <= pixel_i;
            s1_col_q      <= col;
            s1_row_off_q  <= PIX_AW'(v_addr_i) * H_MUL;
        end
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= s1_valid_q & accept_i;
            if (s1_valid_q && accept_i) begin
                wr_addr_q <= {bank_i, s1_row_off_q + PIX_AW'(s1_col_q)};
                wr_data_q <= s1_data_q;
            end
        end
    end

    assign s1_valid_o    = s1_valid_q;
    assign s1_in_range_o = s1_in_range_q;
    assign s1_first_o    = s1_first_q;
    assign s1_last_o     = s1_last_q;
    assign wr_en_o       = wr_en_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;

endmodule

// File: rtl/frame_buffer_writer.sv
// Ping-pong frame buffer writer: captures whole frames into the write bank
// and hands committed banks to the VGA reader at its frame boundary.
module frame_buffer_writer
    import ov7670_pkg::*;
#(
    parameter int  H_WIDTH   = OV_H_WIDTH,
    parameter int  V_WIDTH   = OV_V_WIDTH,
    parameter int  PXL_WIDTH = RGB565_W,
    localparam int PIX_AW    = $clog2(H_WIDTH * V_WIDTH)
) (
    input  logic                     i_clk,
    input  logic                     i_n_reset,
    input  logic                     i_enable,
    input  logic [PXL_WIDTH-1:0]     i_pixel_data,
    input  logic [$clog2(H_WIDTH):0] i_h_addr,
    input  logic [$clog2(V_WIDTH):0] i_v_addr,
    input  logic                     i_valid,
    input  logic                     i_rd_frame_start,
    output logic                     o_wr_en,
    output logic [PIX_AW:0]          o_wr_addr,
    output logic [PXL_WIDTH-1:0]     o_wr_data,
    output logic                     o_rd_bank,
    output logic                     o_frame_done,
    output logic [15:0]              o_frame_cnt,
    output logic [15:0]              o_drop_cnt,
    output logic [15:0]              o_skip_cnt,
    output logic [3:0]               o_state
);

    fbw_state_e  state_q, state_d;
    logic        rd_bank_q, rd_bank_d;
    logic        pending_q, pending_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] skip_cnt_q, skip_cnt_d;

    logic s1_valid, s1_in_range, s1_first, s1_last;
    logic pix_ok, accept, swap, enter, commit, drop, skip_inc;

    fb_addr_pipe #(
        .H_WIDTH   (H_WIDTH),
        .V_WIDTH   (V_WIDTH),
        .PXL_WIDTH (PXL_WIDTH)
    ) u_pipe (
        .i_clk         (i_clk),
        .i_n_reset     (i_n_reset),
        .pixel_i       (i_pixel_data),
        .h_addr_i      (i_h_addr),
        .v_addr_i      (i_v_addr),
        .valid_i       (i_valid),
        .accept_i      (accept),
        .bank_i        (~rd_bank_d),
        .s1_valid_o    (s1_valid),
        .s1_in_range_o (s1_in_range),
        .s1_first_o    (s1_first),
        .s1_last_o     (s1_last),
        .wr_en_o       (o_wr_en),
        .wr_addr_o     (o_wr_addr),
        .wr_data_o     (o_wr_data)
    );

    assign pix_ok = s1_valid & s1_in_range;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_enable) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (pix_ok && s1_first) begin
                    accept  = 1'b1;
                    state_d = s1_last ? ST_COMMIT : ST_CAPTURE;
                end else if (!i_enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (pix_ok) begin
                    accept = 1'b1;
                    if (s1_last) state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = i_enable ? ST_ARMED : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Swap is held off in CAPTURE and COMMIT; the reader keeps its bank until the next pulse
    assign swap   = i_rd_frame_start & pending_q &
                    ((state_q == ST_IDLE) | (state_q == ST_ARMED));
    assign enter  = (state_q == ST_ARMED) & accept;
    assign commit = (state_q == ST_COMMIT);
    assign drop   = s1_valid & ~accept;

    always_comb begin
        rd_bank_d = swap ? ~rd_bank_q : rd_bank_q;
        pending_d = pending_q;
        skip_inc  = 1'b0;
        if (swap) begin
            pending_d = 1'b0;
        end else if (enter && pending_q) begin
            pending_d = 1'b0;
            skip_inc  = 1'b1;
        end
        if (commit) begin
            pending_d = 1'b1;
            skip_inc  = pending_q;
        end
        frame_cnt_d = frame_cnt_q + {15'd0, commit};
        drop_cnt_d  = (drop && drop_cnt_q != '1) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        skip_cnt_d  = (skip_inc && skip_cnt_q != '1) ? skip_cnt_q + 16'd1 : skip_cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state_q     <= ST_IDLE;
            rd_bank_q   <= 1'b0;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            skip_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            skip_cnt_q  <= skip_cnt_d;
        end
    end

    assign o_rd_bank    = rd_bank_q;
    assign o_frame_done = commit;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_drop_cnt   = drop_cnt_q;
    assign o_skip_cnt   = skip_cnt_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Self-checking bench for frame_buffer_writer on a 4x3 frame geometry.
// A frame-level model predicts every BRAM write and the counters.
module tb_frame_buffer_writer;

    localparam int H   = 4;
    localparam int V   = 3;
    localparam int PW  = 16;
    localparam int AW  = $clog2(H * V);
    localparam int HAW = $clog2(H) + 1;
    localparam int VAW = $clog2(V) + 1;

    logic           i_clk = 1'b0;
    logic           i_n_reset = 1'b0;
    logic           i_enable = 1'b0;
    logic [PW-1:0]  i_pixel_data = '0;
    logic [HAW-1:0] i_h_addr = '0;
    logic [VAW-1:0] i_v_addr = '0;
    logic           i_valid = 1'b0;
    logic           i_rd_frame_start = 1'b0;
    logic           o_wr_en;
    logic [AW:0]    o_wr_addr;
    logic [PW-1:0]  o_wr_data;
    logic           o_rd_bank;
    logic           o_frame_done;
    logic [15:0]    o_frame_cnt;
    logic [15:0]    o_drop_cnt;
    logic [15:0]    o_skip_cnt;
    logic [3:0]     o_state;

    frame_buffer_writer #(.H_WIDTH(H), .V_WIDTH(V), .PXL_WIDTH(PW)) dut (
        .i_clk            (i_clk),
        .i_n_reset        (i_n_reset),
        .i_enable         (i_enable),
        .i_pixel_data     (i_pixel_data),
        .i_h_addr         (i_h_addr),
        .i_v_addr         (i_v_addr),
        .i_valid          (i_valid),
        .i_rd_frame_start (i_rd_frame_start),
        .o_wr_en          (o_wr_en),
        .o_wr_addr        (o_wr_addr),
        .o_wr_data        (o_wr_data),
        .o_rd_bank        (o_rd_bank),
        .o_frame_done     (o_frame_done),
        .o_frame_cnt      (o_frame_cnt),
        .o_drop_cnt       (o_drop_cnt),
        .o_skip_cnt       (o_skip_cnt),
        .o_state          (o_state)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 idle, 1 armed, 2 capturing
    int  m_mode;
    bit  m_en, m_rd, m_pend;
    int  m_frames, m_drops, m_skips;
    logic [AW:0]   exp_addr_q[$];
    logic [PW-1:0] exp_data_q[$];

    int          n_wr = 0;
    int          n_done = 0;
    int          pix_seq = 0;
    logic [AW:0] last_wr_addr = '0;
    logic [AW:0] ea;
    logic [PW-1:0] ed;
    int          w0, d0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_frame_done) n_done++;
        if (o_wr_en) begin
            n_wr++;
            last_wr_addr = o_wr_addr;
            if (exp_addr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h expected no write", o_wr_addr);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("wr_addr", 32'(o_wr_addr), 32'(ea));
                check("wr_data", 32'(o_wr_data), 32'(ed));
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic m_reset();
        m_mode   = m_en ? 1 : 0;
        m_rd     = 1'b0;
        m_pend   = 1'b0;
        m_frames = 0;
        m_drops  = 0;
        m_skips  = 0;
    endtask

    task automatic m_push(input int col, input int row, input logic [PW-1:0] d);
        exp_addr_q.push_back({~m_rd, AW'(row * H + col)});
        exp_data_q.push_back(d);
    endtask

    task automatic send(input int h, input int v);
        logic [PW-1:0] d;
        int  col;
        bit  inr;
        pix_seq++;
        d   = 16'hC000 + 16'(pix_seq);
        col = h - 1;
        inr = (h != 0) && (col < H) && (v < V);
        if (m_mode == 1 && inr && col == 0 && v == 0) begin
            if (m_pend) begin
                m_pend = 1'b0;
                if (m_skips < 65535) m_skips++;
            end
            m_mode = 2;
            m_push(col, v, d);
        end else if (m_mode == 2 && inr) begin
            m_push(col, v, d);
            if (col == H - 1 && v == V - 1) begin
                m_frames++;
                if (m_pend && m_skips < 65535) m_skips++;
                m_pend = 1'b1;
                m_mode = m_en ? 1 : 0;
            end
        end else if (m_drops < 65535) begin
            m_drops++;
        end
        tick();
        i_h_addr     = HAW'(h);
        i_v_addr     = VAW'(v);
        i_pixel_data = d;
        i_valid      = 1'b1;
        tick();
        i_valid = 1'b0;
        idle(2);
    endtask

    task automatic frame_part(input int first, input int n);
        for (int k = first; k < first + n; k++) send(k % H + 1, k / H);
    endtask

    task automatic pulse();
        if (m_pend && m_mode != 2) begin
            m_rd   = ~m_rd;
            m_pend = 1'b0;
        end
        tick();
        i_rd_frame_start = 1'b1;
        tick();
        i_rd_frame_start = 1'b0;
        tick();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_frame_cnt"}, 32'(o_frame_cnt), 32'(m_frames));
        check({tag, "_drop_cnt"}, 32'(o_drop_cnt), 32'(m_drops));
        check({tag, "_skip_cnt"}, 32'(o_skip_cnt), 32'(m_skips));
        check({tag, "_rd_bank"}, 32'(o_rd_bank), 32'(m_rd));
        check({tag, "_writes_left"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(o_wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(o_wr_data), 32'd0);
        check({tag, "_rd_bank"}, 32'(o_rd_bank), 32'd0);
        check({tag, "_frame_done"}, 32'(o_frame_done), 32'd0);
        check({tag, "_frame_cnt"}, 32'(o_frame_cnt), 32'd0);
        check({tag, "_drop_cnt"}, 32'(o_drop_cnt), 32'd0);
        check({tag, "_skip_cnt"}, 32'(o_skip_cnt), 32'd0);
        check({tag, "_state"}, 32'(o_state), 32'h1);
    endtask

    initial begin
        m_en = 1'b0;
        m_reset();
        idle(3);
        check_reset("rst");
        i_n_reset = 1'b1;
        idle(2);
        check("idle_state", 32'(o_state), 32'h1);
        i_enable = 1'b1;
        m_en     = 1'b1;
        m_mode   = 1;
        idle(2);
        check("armed_state", 32'(o_state), 32'h2);

        // First full frame lands in bank 1
        w0 = n_wr; d0 = n_done;
        frame_part(0, H * V);
        idle(3);
        check("a_writes", 32'(n_wr - w0), 32'd12);
        check("a_done", 32'(n_done - d0), 32'd1);
        check("a_frame_cnt", 32'(o_frame_cnt), 32'd1);
        check("a_last_addr", 32'(last_wr_addr), 32'h1B);
        check_model("a");

        pulse();
        idle(2);
        check("b_rd_bank", 32'(o_rd_bank), 32'd1);
        check_model("b");

        // Armed: non-origin pixels and an out-of-range column are dropped
        w0 = n_wr;
        send(2, 0);
        send(3, 1);
        send(5, 0);
        idle(3);
        check("c_drops", 32'(o_drop_cnt), 32'd3);
        check("c_writes", 32'(n_wr - w0), 32'd0);
        check_model("c");

        // Short frame restarts at origin, then a full frame commits to bank 0
        w0 = n_wr; d0 = n_done;
        frame_part(0, 6);
        frame_part(0, H * V);
        idle(3);
        check("d_writes", 32'(n_wr - w0), 32'd18);
        check("d_done", 32'(n_done - d0), 32'd1);
        check("d_frame_cnt", 32'(o_frame_cnt), 32'd2);
        check("d_last_addr", 32'(last_wr_addr), 32'h0B);
        check("d_skip", 32'(o_skip_cnt), 32'd0);
        check_model("d");

        // Second commit without a reader pulse: skip counted at the new origin
        frame_part(0, 1);
        idle(1);
        check("e_skip_at_sof", 32'(o_skip_cnt), 32'd1);
        frame_part(1, H * V - 1);
        idle(3);
        check("e_frame_cnt", 32'(o_frame_cnt), 32'd3);
        check("e_rd_bank", 32'(o_rd_bank), 32'd1);
        check_model("e");

        // Reader pulse mid-capture is ignored, the one after commit swaps
        frame_part(0, 5);
        pulse();
        check("f_mid_rd_bank", 32'(o_rd_bank), 32'd1);
        frame_part(5, H * V - 5);
        idle(3);
        check("f_frame_cnt", 32'(o_frame_cnt), 32'd4);
        check("f_skip", 32'(o_skip_cnt), 32'd2);
        pulse();
        idle(2);
        check("f_rd_bank", 32'(o_rd_bank), 32'd0);
        check_model("f");

        // Reset one cycle after a valid origin pixel: its write never issues
        w0 = n_wr;
        tick();
        i_h_addr     = HAW'(1);
        i_v_addr     = '0;
        i_pixel_data = 16'hBEEF;
        i_valid      = 1'b1;
        tick();
        i_valid   = 1'b0;
        i_n_reset = 1'b0;
        idle(3);
        check("g_no_write", 32'(n_wr - w0), 32'd0);
        check_reset("g");
        i_n_reset = 1'b1;
        m_reset();
        idle(3);
        check("g_armed", 32'(o_state), 32'h2);
        check_model("g");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
